// File: rtl/aca_csu_vl_adder.sv
// Pipelined carry-select approximate adder with speculative block carries and an optional exact-fix cycle.
// Define ACA_ERR_STATS_EN to add saturating err_cnt/fix_cnt delivery counters.
module aca_csu_vl_adder #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned BLK   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             approx_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_sum,
   output logic             out_err,
   output logic             out_fixed
`ifdef ACA_ERR_STATS_EN
   ,
   output logic [15:0]      err_cnt,
   output logic [15:0]      fix_cnt
`endif
);

   localparam int unsigned NBLK = WIDTH / BLK;

   typedef enum logic [1:0] {IDLE, EVAL, FIX, OUT} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             mode_q;
   logic             valid_q;
   logic             err_q;
   logic             fixed_q;
   logic [WIDTH:0]   sum_q;

   logic [NBLK-2:0]  gen;
   logic [NBLK-2:0]  prop;
   logic [BLK:0]     blk_raw;
   logic [BLK:0]     blk_sum;
   logic             spec_c;
   logic             chain_c;
   logic             spec_err;
   logic [WIDTH:0]   apx_sum;
   logic [WIDTH:0]   exact_sum;

   // Speculative sum: each block takes the previous block's carry-out computed with cin=0.
   always_comb begin
      gen       = '0;
      prop      = '0;
      blk_raw   = '0;
      blk_sum   = '0;
      spec_c    = 1'b0;
      chain_c   = 1'b0;
      spec_err  = 1'b0;
      apx_sum   = '0;
      for (int unsigned k = 0; k < NBLK; k++) begin
         blk_raw = {1'b0, a_q[k*BLK +: BLK]} + {1'b0, b_q[k*BLK +: BLK]};
         blk_sum = blk_raw + (BLK+1)'(spec_c);
         apx_sum[k*BLK +: BLK] = blk_sum[BLK-1:0];
         spec_c  = blk_raw[BLK];
      end
      apx_sum[WIDTH] = blk_sum[BLK];
      for (int unsigned k = 0; k < NBLK - 1; k++) begin
         gen[k]  = (({1'b0, a_q[k*BLK +: BLK]} + {1'b0, b_q[k*BLK +: BLK]}) >> BLK) != '0;
         prop[k] = &(a_q[k*BLK +: BLK] ^ b_q[k*BLK +: BLK]);
      end
      // A speculated carry is wrong only where a fully-propagating block receives a true carry.
      for (int unsigned k = 1; k < NBLK; k++) begin
         spec_err = spec_err | (prop[k-1] & chain_c);
         chain_c  = gen[k-1] | (prop[k-1] & chain_c);
      end
      exact_sum = {1'b0, a_q} + {1'b0, b_q};
   end

   assign in_ready  = (state_q == IDLE) || ((state_q == OUT) && out_ready);
   assign out_valid = valid_q;
   assign out_sum   = sum_q;
   assign out_err   = err_q;
   assign out_fixed = fixed_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         mode_q  <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         fixed_q <= 1'b0;
         sum_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= in_a;
                  b_q     <= in_b;
                  mode_q  <= approx_mode;
                  state_q <= EVAL;
               end
            end
            EVAL: begin
               if (!spec_err || mode_q) begin
                  sum_q   <= apx_sum;
                  err_q   <= spec_err;
                  fixed_q <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= OUT;
               end else begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               sum_q   <= exact_sum;
               err_q   <= 1'b0;
               fixed_q <= 1'b1;
               valid_q <= 1'b1;
               state_q <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  valid_q <= 1'b0;
                  if (in_valid) begin
                     a_q     <= in_a;
                     b_q     <= in_b;
                     mode_q  <= approx_mode;
                     state_q <= EVAL;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef ACA_ERR_STATS_EN
   logic [15:0] err_cnt_q;
   logic [15:0] err_cnt_d;
   logic [15:0] fix_cnt_q;
   logic [15:0] fix_cnt_d;

   // Saturating counts of delivered inexact / corrected results.
   always_comb begin
      err_cnt_d = err_cnt_q;
      fix_cnt_d = fix_cnt_q;
      if (valid_q && out_ready) begin
         if (err_q && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
         if (fixed_q && (fix_cnt_q != 16'hFFFF)) fix_cnt_d = fix_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q <= '0;
         fix_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
         fix_cnt_q <= fix_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
   assign fix_cnt = fix_cnt_q;
`endif

endmodule

// File: tb/tb_aca_csu_vl_adder.sv
// Self-checking bench for aca_csu_vl_adder (WIDTH=24, BLK=8): directed table, hand sequences, random scoreboard.
module tb_aca_csu_vl_adder;

   localparam int unsigned W  = 24;
   localparam int unsigned B  = 8;
   localparam int unsigned NB = W / B;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          approx_mode;
   logic          out_valid;
   logic          out_ready;
   logic [W:0]    out_sum;
   logic          out_err;
   logic          out_fixed;
`ifdef ACA_ERR_STATS_EN
   logic [15:0]   err_cnt;
   logic [15:0]   fix_cnt;
`endif

   always #5 clk = ~clk;

   aca_csu_vl_adder #(.WIDTH(W), .BLK(B)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .approx_mode (approx_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sum     (out_sum),
      .out_err     (out_err),
      .out_fixed   (out_fixed)
`ifdef ACA_ERR_STATS_EN
      ,
      .err_cnt     (err_cnt),
      .fix_cnt     (fix_cnt)
`endif
   );

   typedef struct packed {
      logic [W:0] sum;
      logic       err;
      logic       fixed;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         mode;
      logic [W:0]   sum;
      logic         err;
      logic         fixed;
      int           lat;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[8];
   int   n_checks = 0;
   int   n_errors = 0;
   int   exp_err_n = 0;
   int   exp_fix_n = 0;
   logic rnd_bp = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: block k adds the previous block's carry-out taken with cin=0.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W:0] apx, output logic err);
      logic [B:0] raw;
      logic [B:0] t;
      logic       s;
      logic [W:0] ex;
      s   = 1'b0;
      t   = '0;
      apx = '0;
      for (int k = 0; k < int'(NB); k++) begin
         raw = {1'b0, a[k*B +: B]} + {1'b0, b[k*B +: B]};
         t   = raw + (B+1)'(s);
         apx[k*B +: B] = t[B-1:0];
         s   = raw[B];
      end
      apx[W] = t[B];
      ex  = {1'b0, a} + {1'b0, b};
      err = (apx != ex);
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         exp_err_n = 0;
         exp_fix_n = 0;
      end else if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", 64'd1, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("out_sum", 64'(out_sum), 64'(mon_e.sum));
            chk("out_err", 64'(out_err), 64'(mon_e.err));
            chk("out_fixed", 64'(out_fixed), 64'(mon_e.fixed));
            if (mon_e.err) exp_err_n++;
            if (mon_e.fixed) exp_fix_n++;
         end
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic mode,
                       input logic [W:0] es, input logic ee, input logic ef, output int waited);
      logic acc;
      sb.push_back(exp_t'{sum: es, err: ee, fixed: ef});
      in_a        = a;
      in_b        = b;
      approx_mode = mode;
      in_valid    = 1'b1;
      waited      = 0;
      acc         = 1'b0;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1'b1;
         end else begin
            waited++;
            @(posedge clk);
            #1;
            if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
         end
      end
      if (acc) begin
         @(posedge clk);
         #1;
      end else begin
         void'(sb.pop_back());
      end
      chk("accept", 64'(acc), 64'd1);
      in_valid = 1'b0;
      if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   // Edges counted from the accept edge (inclusive) up to the one that raises out_valid.
   task automatic measure_lat(output int lat);
      lat = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) break;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
      @(posedge clk);
      #1;
      chk("drain", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int           w;
      int           lat;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rm;
      logic [W:0]   apx;
      logic         merr;
      logic         seen;

      vecs[0] = '{24'h000001, 24'h0000FF, 1'b0, 25'h0000100, 1'b0, 1'b0, 2};
      vecs[1] = '{24'h00FF01, 24'h0000FF, 1'b0, 25'h0010000, 1'b0, 1'b1, 3};
      vecs[2] = '{24'h00FF01, 24'h0000FF, 1'b1, 25'h0000000, 1'b1, 1'b0, 2};
      vecs[3] = '{24'hFFFFFF, 24'h000001, 1'b0, 25'h1000000, 1'b0, 1'b1, 3};
      vecs[4] = '{24'hFFFFFF, 24'h000001, 1'b1, 25'h0FF0000, 1'b1, 1'b0, 2};
      vecs[5] = '{24'h800000, 24'h800000, 1'b0, 25'h1000000, 1'b0, 1'b0, 2};
      vecs[6] = '{24'h000000, 24'h000000, 1'b1, 25'h0000000, 1'b0, 1'b0, 2};
      vecs[7] = '{24'h123456, 24'h654321, 1'b0, 25'h0777777, 1'b0, 1'b0, 2};

      rst         = 1'b1;
      in_valid    = 1'b0;
      in_a        = '0;
      in_b        = '0;
      approx_mode = 1'b0;
      out_ready   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_sum", 64'(out_sum), 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
      chk("rst_out_fixed", 64'(out_fixed), 64'd0);
`ifdef ACA_ERR_STATS_EN
      chk("rst_err_cnt", 64'(err_cnt), 64'd0);
      chk("rst_fix_cnt", 64'(fix_cnt), 64'd0);
`endif
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) begin
         send(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].sum, vecs[i].err, vecs[i].fixed, w);
         measure_lat(lat);
         chk("latency", 64'(lat), 64'(vecs[i].lat));
         drain();
      end

      // Backpressure: result must hold while the consumer stalls, then a same-edge reaccept.
      out_ready = 1'b0;
      send(24'h00FF01, 24'h0000FF, 1'b0, 25'h0010000, 1'b0, 1'b1, w);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = out_valid;
      end
      chk("bp_valid_rise", 64'(seen), 64'd1);
      for (int i = 0; i < 5; i++) begin
         if (i != 0) @(negedge clk);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_out_sum", 64'(out_sum), 64'h0010000);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(24'h000001, 24'h0000FF, 1'b0, 25'h0000100, 1'b0, 1'b0, w);
      chk("b2b_same_edge", 64'(w), 64'd0);
      chk("b2b_valid_drop", 64'(out_valid), 64'd0);
      measure_lat(lat);
      chk("b2b_latency", 64'(lat), 64'd2);
      drain();

      // Reset while the correction cycle is in progress.
      send(24'h00FF01, 24'h0000FF, 1'b0, 25'h0010000, 1'b0, 1'b1, w);
      @(posedge clk);
      #1;
      chk("fix_state_no_valid", 64'(out_valid), 64'd0);
      rst = 1'b1;
      #1;
      chk("midfix_out_valid", 64'(out_valid), 64'd0);
      chk("midfix_in_ready", 64'(in_ready), 64'd1);
      chk("midfix_out_sum", 64'(out_sum), 64'd0);
      chk("midfix_out_fixed", 64'(out_fixed), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      send(24'hFFFFFF, 24'h000001, 1'b0, 25'h1000000, 1'b0, 1'b1, w);
      measure_lat(lat);
      chk("post_rst_latency", 64'(lat), 64'd3);
      drain();

      // Random operands with random consumer stalls; half are propagate-heavy.
      rnd_bp = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         ra = W'($urandom);
         if ($urandom_range(0, 1) == 1) rb = ~ra ^ (W'(1) << $urandom_range(0, W - 1));
         else rb = W'($urandom);
         rm = 1'($urandom_range(0, 1));
         model(ra, rb, apx, merr);
         send(ra, rb, rm,
              (merr && rm) ? apx : ({1'b0, ra} + {1'b0, rb}),
              merr && rm, merr && !rm, w);
      end
      rnd_bp    = 1'b0;
      out_ready = 1'b1;
      drain();

`ifdef ACA_ERR_STATS_EN
      chk("err_cnt", 64'(err_cnt), 64'(exp_err_n));
      chk("fix_cnt", 64'(fix_cnt), 64'(exp_fix_n));
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
